// File: rtl/mult_product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants, types and helpers for the 4x4 multiplier
//                and its downstream product accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Product width produced by the 4x4 multiplier.
  localparam int PROD_W_DEFAULT = 8;

  // Accumulator controller states.
  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_t;

  // Returns the width of a counter that must be able to hold 0..n.
  function automatic int calc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_product_accumulator_sat_accum_add.sv
`default_nettype none
// ============================================================================
//  Module      : sat_accum_add
//  Description : Combinational unsigned accumulate step: adds a zero-extended
//                addend to an accumulator and clamps at all-ones on carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_accum_add #(
  parameter int ACC_W  = 10,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] addend_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  // One extra bit keeps the carry-out visible.
  logic [ACC_W:0] w_wide;

  // Full-width add, then clamp to the largest representable value on carry.
  always_comb begin
    w_wide = (ACC_W + 1)'(acc_i) + (ACC_W + 1)'(addend_i);
    ovf_o  = w_wide[ACC_W];
    sum_o  = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];
  end

endmodule : sat_accum_add
`default_nettype wire

// File: rtl/mult_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : mult_product_accumulator
//  Description : Accumulates up to NUM_TERMS unsigned products into a
//                saturating sum and presents each completed group through a
//                valid/ready output until it is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter  int PROD_W    = PROD_W_DEFAULT,
  parameter  int NUM_TERMS = 4,
  parameter  int ACC_W     = 10,
  localparam int CNT_W     = calc_cnt_w(NUM_TERMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(NUM_TERMS);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_ovf;
  logic [CNT_W-1:0] w_cnt_inc;

  sat_accum_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc_i    (acc_q),
    .addend_i (in_prod),
    .sum_o    (w_add_sum),
    .ovf_o    (w_add_ovf)
  );

  assign w_cnt_inc = cnt_q + CNT_W'(1);

  // Next-state: collect terms in ACC, close the group on in_last or the final
  // term, then wait in HOLD until the result is taken and start from zero.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = w_add_sum;
          ovf_d = ovf_q | w_add_ovf;
          cnt_d = w_cnt_inc;
          if (in_last || (w_cnt_inc == C_LAST_CNT)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and datapath registers; reset discards any partial or held group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from registers, so no input reaches an output
  // combinationally and in_ready never depends on out_ready.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule : mult_product_accumulator
`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_product_accumulator
//  Description : Self-checking bench; a 10-bit and a 9-bit accumulator share
//                one stimulus stream and are compared every cycle against a
//                group-level arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_product_accumulator;

  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_prod = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [9:0] a_out_sum;
  logic [2:0] a_out_count;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [8:0] b_out_sum;
  logic [2:0] b_out_count;

  int n_vec = 0;
  int n_err = 0;

  // Model: true (unclamped) sum of the current group, its term count and
  // whether the group has been closed and is awaiting consumption.
  int m_sum  = 0;
  int m_cnt  = 0;
  bit m_hold = 1'b0;

  mult_product_accumulator #(.PROD_W(8), .NUM_TERMS(NT), .ACC_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
    .out_ovf(a_out_ovf)
  );

  mult_product_accumulator #(.PROD_W(8), .NUM_TERMS(NT), .ACC_W(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_prod(in_prod), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
    .out_ovf(b_out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (s > mx) ? mx : s;
  endfunction

  // Compare every output of both instances with the model.
  task automatic check_all();
    chk("in_ready10",  32'(a_in_ready),  32'(!m_hold));
    chk("in_ready9",   32'(b_in_ready),  32'(!m_hold));
    chk("out_valid10", 32'(a_out_valid), 32'(m_hold));
    chk("out_valid9",  32'(b_out_valid), 32'(m_hold));
    chk("out_sum10",   32'(a_out_sum),   32'(clamp(m_sum, 10)));
    chk("out_sum9",    32'(b_out_sum),   32'(clamp(m_sum, 9)));
    chk("out_count10", 32'(a_out_count), 32'(m_cnt));
    chk("out_count9",  32'(b_out_count), 32'(m_cnt));
    chk("out_ovf10",   32'(a_out_ovf),   32'(m_sum > 1023));
    chk("out_ovf9",    32'(b_out_ovf),   32'(m_sum > 511));
  endtask

  // One clock: advance the model on the rising edge using the inputs that
  // were stable across it, then check at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      m_sum = 0; m_cnt = 0; m_hold = 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        m_sum += int'(in_prod);
        m_cnt += 1;
        if (in_last || m_cnt == NT) m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_sum = 0; m_cnt = 0; m_hold = 1'b0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input int p, input bit l, input bit r);
    in_valid  = v;
    in_prod   = 8'(p);
    in_last   = l;
    out_ready = r;
    cycle();
  endtask

  initial begin
    int t_rise[2];
    int exp_grp[2];
    int grp;
    int cyc;
    int nxt;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_sum",   32'(a_out_sum),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Full group of 225s: 900 unclamped, 511 with overflow in the 9-bit unit
    repeat (4) drive(1'b1, 225, 1'b0, 1'b1);
    chk("full_sum10", 32'(a_out_sum),   32'd900);
    chk("full_cnt",   32'(a_out_count), 32'd4);
    chk("sat_sum9",   32'(b_out_sum),   32'd511);
    chk("sat_ovf9",   32'(b_out_ovf),   32'd1);
    drive(1'b0, 0, 1'b0, 1'b1);
    chk("bubble_ready", 32'(a_in_ready), 32'd1);

    // Group after saturation starts clean
    drive(1'b1, 1, 1'b0, 1'b1);
    drive(1'b1, 2, 1'b1, 1'b1);
    chk("post_sat_sum9", 32'(b_out_sum), 32'd3);
    chk("post_sat_ovf9", 32'(b_out_ovf), 32'd0);
    drive(1'b0, 0, 1'b0, 1'b1);

    // Early close then backpressure with a product that must be ignored
    drive(1'b1, 10, 1'b0, 1'b1);
    drive(1'b1, 20, 1'b1, 0);
    chk("early_sum", 32'(a_out_sum),   32'd30);
    chk("early_cnt", 32'(a_out_count), 32'd2);
    repeat (3) begin
      drive(1'b1, 99, 1'b0, 1'b0);
      chk("bp_sum", 32'(a_out_sum), 32'd30);
    end
    drive(1'b1, 99, 1'b0, 1'b1);
    chk("bp_release", 32'(a_out_valid), 32'd0);
    drive(1'b0, 0, 1'b0, 1'b1);
    chk("bp_cleared", 32'(a_out_sum), 32'd0);

    // Asynchronous reset in the middle of a group
    drive(1'b1, 50, 1'b0, 1'b1);
    drive(1'b1, 60, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(a_out_sum),   32'd0);
    chk("arst_cnt", 32'(a_out_count), 32'd0);
    m_sum = 0; m_cnt = 0; m_hold = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(1'b1, 7, 1'b1, 1'b1);
    chk("post_rst_sum", 32'(a_out_sum),   32'd7);
    chk("post_rst_cnt", 32'(a_out_count), 32'd1);
    drive(1'b0, 0, 1'b0, 1'b1);

    // Back-to-back groups: source holds each product until accepted
    exp_grp[0] = 10; exp_grp[1] = 26;
    grp = 0; cyc = 0; nxt = 1;
    while (nxt <= 8 && cyc < 30) begin
      bit acc;
      acc = a_in_ready;
      drive(1'b1, nxt, 1'b0, 1'b1);
      cyc++;
      if (acc) nxt++;
      if (a_out_valid && grp < 2) begin
        chk("b2b_sum", 32'(a_out_sum), 32'(exp_grp[grp]));
        t_rise[grp] = cyc;
        grp++;
      end
    end
    chk("b2b_groups", 32'(grp), 32'd2);
    if (grp == 2) chk("b2b_spacing", 32'(t_rise[1] - t_rise[0]), 32'd5);
    drive(1'b0, 0, 1'b0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mult_product_accumulator
`default_nettype wire

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream consumer of the 4x4 multiplier's 8-bit product `P`.
- Accumulates a group of products into a wider sum, i.e. the accumulate half of a dot-product / MAC datapath.
- Input side: valid/ready handshake; output side: registered sum with valid/ready handshake.
- A group closes after NUM_TERMS products or earlier on `in_last`.

Parameters:
- PROD_W, 8: width of incoming product (matches 4x4 multiplier output).
- NUM_TERMS, 4: maximum products per group; must be >= 1.
- ACC_W, 10: accumulator/sum width; must be >= PROD_W; saturates on overflow.
- CNT_W, $clog2(NUM_TERMS+1): derived localparam, not overridable; width of term counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  product present on in_prod.
- in_ready  out  1  block can accept a product this cycle.
- in_prod  in  PROD_W  unsigned product from multiplier.
- in_last  in  1  qualifies in_valid: this product closes the group.
- out_valid  out  1  out_sum/out_count/out_ovf hold a completed group.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  unsigned accumulated sum (saturated).
- out_count  out  CNT_W  number of products in the group, 1..NUM_TERMS.
- out_ovf  out  1  sum saturated at some point in this group (sticky per group).

Behaviour:
- Two states: ACC (collecting) and HOLD (result presented).
- Reset (async assert, sync-safe release):
  - state=ACC; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0; in_ready=1 once reset is released.
- in_ready = (state==ACC), combinational from state only; no dependence on out_ready.
- Accept = in_valid && in_ready. On accept in ACC:
  - acc <= sat(acc + zero_ext(in_prod)); sat clamps to 2^ACC_W-1.
  - ovf <= ovf | carry-out.
  - cnt <= cnt+1.
- Group closes on an accepted term when in_last==1 or cnt+1==NUM_TERMS:
  - Next cycle: state=HOLD, out_valid=1.
  - out_sum/out_count/out_ovf reflect the updated acc/cnt/ovf.
  - Latency: out_valid rises one cycle after the accepting edge of the final term.
- in_last together with the NUM_TERMS-th term: single completion, no empty extra group.
- in_last and in_prod are ignored when not accepted (in_valid=0 or in HOLD).
- HOLD:
  - in_ready=0.
  - out_sum, out_count, out_ovf held stable while out_valid && !out_ready.
  - On out_ready=1: next cycle acc=0, cnt=0, ovf=0, out_valid=0, state=ACC.
  - Exactly one bubble cycle before the next product is accepted.
- Throughput: a full group of N terms with no stalls takes N+1 cycles, repeating.
- out_sum, out_count and out_ovf are the registered acc, cnt and ovf. They read 0 whenever state==ACC and no term has been accepted yet.
- Reset mid-group or mid-HOLD discards everything immediately; the next group starts from zero.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Decomposition:
- Shared package mult_pkg:
  - PROD_W default constant (8), shared with the multiplier.
  - State enum typedef acc_state_t {ACC, HOLD}.
  - Helper for the CNT_W derivation.
- One sub-module: sat_accum_add (combinational).
  - Inputs: ACC_W accumulator, PROD_W addend.
  - Outputs: saturated ACC_W sum and overflow flag.
  - Reusable by later MAC blocks.

Test Plan:
- Full group, no stalls: four products of 225 (15*15), out_ready=1 -> out_valid 1 cycle after 4th accept; out_sum=900, out_count=4, out_ovf=0; in_ready low exactly 1 cycle.
- Early close: products 10, 20 with in_last on 20 -> out_sum=30, out_count=2, out_ovf=0; next group starts from 0.
- Backpressure: hold out_ready=0 for 3 cycles after completion while driving in_valid=1, in_prod=99 -> out_sum/out_count unchanged, in_ready=0, 99 never accumulated; release -> out_valid drops next cycle.
- Saturation (ACC_W=9): four products of 225 -> out_sum=511, out_ovf=1, out_count=4; following group of 1+2 -> out_sum=3, out_ovf=0.
- Reset mid-group: accept 50, 60, assert rst_n=0 -> all outputs 0 asynchronously; after release, accept 7 with in_last -> out_sum=7, out_count=1.
- Back-to-back groups: continuous in_valid, out_ready=1, NUM_TERMS=4, products 1..8 -> sums 10 then 26, each group 5 cycles apart; no term lost or duplicated.
